// File: rtl/alu_pkg.sv
// Shared definitions for the iterative ALU sequencer.
// Holds opcode constants, datapath select encodings, FSM state encodings
// and a small opcode legality helper.
package alu_pkg;

    // Command-interface opcodes (1xx is illegal)
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;

    // Datapath operation select encodings
    localparam logic [1:0] SEL_ADD = 2'b00;
    localparam logic [1:0] SEL_SUB = 2'b01;
    localparam logic [1:0] SEL_MUL = 2'b10;
    localparam logic [1:0] SEL_DIV = 2'b11;

    // Sequencer state encodings
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_LOAD = 2'b01;
    localparam logic [1:0] ST_EXEC = 2'b10;
    localparam logic [1:0] ST_DONE = 2'b11;

    // An opcode is legal only when its top bit is clear
    function automatic logic op_is_legal(input logic [2:0] op);
        return ~op[2];
    endfunction

endpackage

// File: rtl/iter_counter.sv
// Loadable down-counter tracking the remaining MUL/DIV iterations.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   clr_i        clear to zero (highest priority)
//   load_i       load load_val_i
//   load_val_i   value to load
//   dec_i        decrement by one
//   count_o      current count
//   is_one_o     count equals one (last iteration)
module iter_counter #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] count_o,
    output logic             is_one_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear beats load beats decrement
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o  = cnt_q;
    assign is_one_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/alu_sequencer.sv
// Control sequencer for the iterative ALU: accepts an operation request,
// issues load/compute strobes to the datapath and returns a one-cycle done
// pulse with an error flag (illegal opcode, divide by zero, abort).
// Optional feature macro: ALU_SEQ_ABORT_EN adds the abort input.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   start          operation request, accepted only while ready
//   opcode         000 ADD, 001 SUB, 010 MUL, 011 DIV, 1xx illegal
//   divisor_zero   datapath flag, sampled in the LOAD cycle
//   abort          (ALU_SEQ_ABORT_EN only) terminate LOAD/EXEC with error
//   ready, busy    IDLE / non-IDLE indicators
//   load, compute  datapath strobes
//   select_op      datapath operation select
//   iter           remaining iterations during EXEC, else zero
//   done, error    completion pulse and its error flag
// All outputs are decoded from registered state only.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [2:0]                   opcode,
    input  logic                         divisor_zero,
`ifdef ALU_SEQ_ABORT_EN
    input  logic                         abort,
`endif
    output logic                         ready,
    output logic                         busy,
    output logic                         load,
    output logic                         compute,
    output logic [1:0]                   select_op,
    output logic [$clog2(DATA_W+1)-1:0]  iter,
    output logic                         done,
    output logic                         error
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    logic [1:0]       state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic             err_q, err_d;
    logic             cnt_clr, cnt_load, cnt_dec;
    logic [CNT_W-1:0] cnt;
    logic             cnt_is_one;
    logic             abort_w;

`ifdef ALU_SEQ_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    // Next-state and counter control
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        err_d    = err_q;
        cnt_clr  = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d = opcode[1:0];
                    if (op_is_legal(opcode)) begin
                        err_d   = 1'b0;
                        state_d = ST_LOAD;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_LOAD: begin
                if (abort_w) begin
                    err_d   = 1'b1;
                    cnt_clr = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    case (op_q)
                        SEL_MUL: begin
                            cnt_load = 1'b1;
                            state_d  = ST_EXEC;
                        end
                        SEL_DIV: begin
                            // Zero divisor skips the iterations entirely
                            if (divisor_zero) begin
                                err_d   = 1'b1;
                                state_d = ST_DONE;
                            end else begin
                                cnt_load = 1'b1;
                                state_d  = ST_EXEC;
                            end
                        end
                        default: state_d = ST_DONE;
                    endcase
                end
            end
            ST_EXEC: begin
                if (abort_w) begin
                    err_d   = 1'b1;
                    cnt_clr = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_dec = 1'b1;
                    if (cnt_is_one) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= SEL_ADD;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            err_q   <= err_d;
        end
    end

    iter_counter #(
        .CNT_W (CNT_W)
    ) u_iter_counter (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (cnt_clr),
        .load_i     (cnt_load),
        .load_val_i (CNT_W'(DATA_W)),
        .dec_i      (cnt_dec),
        .count_o    (cnt),
        .is_one_o   (cnt_is_one)
    );

    // Output decode from registered state
    assign ready     = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign load      = (state_q == ST_LOAD);
    assign compute   = (state_q == ST_EXEC);
    assign done      = (state_q == ST_DONE);
    assign error     = (state_q == ST_DONE) && err_q;
    assign select_op = (state_q == ST_IDLE) ? SEL_ADD : op_q;
    assign iter      = (state_q == ST_EXEC) ? cnt : '0;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer (DATA_W=8): table of single
// operations plus hand-written multi-cycle sequences.
module tb_alu_sequencer;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [2:0]       opcode;
    logic             divisor_zero;
    logic             abort;
    logic             ready, busy, load, compute, done, error;
    logic [1:0]       select_op;
    logic [CNT_W-1:0] iter;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_sequencer #(.DATA_W(DATA_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .opcode       (opcode),
        .divisor_zero (divisor_zero),
`ifdef ALU_SEQ_ABORT_EN
        .abort        (abort),
`endif
        .ready        (ready),
        .busy         (busy),
        .load         (load),
        .compute      (compute),
        .select_op    (select_op),
        .iter         (iter),
        .done         (done),
        .error        (error)
    );

    typedef struct {
        logic [2:0] op;
        logic       dz;
        int         done_cyc;
        logic       err;
        int         loads;
        int         computes;
        logic [1:0] sel;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic check_idle(input string nm);
        check({nm, ".ready"},   32'(ready),     1);
        check({nm, ".busy"},    32'(busy),      0);
        check({nm, ".load"},    32'(load),      0);
        check({nm, ".compute"}, 32'(compute),   0);
        check({nm, ".done"},    32'(done),      0);
        check({nm, ".error"},   32'(error),     0);
        check({nm, ".sel"},     32'(select_op), 0);
        check({nm, ".iter"},    32'(iter),      0);
    endtask

    // Called at a negedge while IDLE; returns just after the acceptance edge
    task automatic issue(input logic [2:0] op, input logic dz);
        start        = 1'b1;
        opcode       = op;
        divisor_zero = dz;
        @(posedge clk);
        #1;
        start  = 1'b0;
        opcode = ~op;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string nm;
        int nload, ncomp, dcyc;
        nm    = $sformatf("vec%0d", idx);
        nload = 0;
        ncomp = 0;
        dcyc  = -1;
        check({nm, ".ready_before"}, 32'(ready), 1);
        issue(v.op, v.dz);
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (load) begin
                nload++;
                check({nm, ".load_sel"}, 32'(select_op), 32'(v.sel));
            end
            if (compute) begin
                check($sformatf("%s.iter%0d", nm, ncomp), 32'(iter), DATA_W - ncomp);
                ncomp++;
            end
            if (done) begin
                dcyc = c;
                check({nm, ".error"},    32'(error),     32'(v.err));
                check({nm, ".done_sel"}, 32'(select_op), 32'(v.sel));
                break;
            end
        end
        check({nm, ".done_cycle"}, dcyc,  v.done_cyc);
        check({nm, ".loads"},      nload, v.loads);
        check({nm, ".computes"},   ncomp, v.computes);
        @(negedge clk);
        check({nm, ".ready_after"}, 32'(ready), 1);
        check({nm, ".done_after"},  32'(done),  0);
    endtask

    initial begin
        int ndone, ncomp;

        vecs[0] = '{3'b000, 1'b0,  2, 1'b0, 1, 0, 2'b00};
        vecs[1] = '{3'b001, 1'b0,  2, 1'b0, 1, 0, 2'b01};
        vecs[2] = '{3'b010, 1'b0, 10, 1'b0, 1, 8, 2'b10};
        vecs[3] = '{3'b011, 1'b0, 10, 1'b0, 1, 8, 2'b11};
        vecs[4] = '{3'b011, 1'b1,  2, 1'b1, 1, 0, 2'b11};
        vecs[5] = '{3'b101, 1'b0,  1, 1'b1, 0, 0, 2'b01};
        vecs[6] = '{3'b100, 1'b0,  1, 1'b1, 0, 0, 2'b00};
        vecs[7] = '{3'b111, 1'b1,  1, 1'b1, 0, 0, 2'b11};

        rst          = 1'b1;
        start        = 1'b0;
        opcode       = 3'b000;
        divisor_zero = 1'b0;
        abort        = 1'b0;
        repeat (2) @(negedge clk);
        check_idle("reset");
        rst = 1'b0;
        @(negedge clk);

        // Error from an illegal op must clear on the following legal op
        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], i);
        end
        run_vec(vecs[0], 8);

        // Start during EXEC and DONE ignored; accepted the cycle after DONE
        ndone = 0;
        ncomp = 0;
        issue(3'b010, 1'b0);
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (done) ndone++;
            if (compute && c <= 10) ncomp++;
            if (c == 10) begin
                check("b2b.mul_done",  32'(done),  1);
                check("b2b.mul_error", 32'(error), 0);
            end
            if (c == 11) check("b2b.ready_after_done", 32'(ready), 1);
            if (c == 12) begin
                check("b2b.sub_load", 32'(load),      1);
                check("b2b.sub_sel",  32'(select_op), 1);
            end
            if (c == 13) check("b2b.sub_done", 32'(done), 1);
            if (c == 5) begin
                start  = 1'b1;
                opcode = 3'b000;
            end
            if (c == 6)  start = 1'b0;
            if (c == 10) begin
                start  = 1'b1;
                opcode = 3'b001;
            end
            if (c == 12) start = 1'b0;
        end
        check("b2b.mul_computes", ncomp, 8);
        check("b2b.done_count",   ndone, 2);

        // Reset in EXEC cycle 4 abandons the operation
        ndone = 0;
        issue(3'b010, 1'b0);
        repeat (5) @(negedge clk);
        check("rstmid.compute_before", 32'(compute), 1);
        check("rstmid.iter_before",    32'(iter),    5);
        rst = 1'b1;
        #1;
        check_idle("rstmid");
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("rstmid.no_done", ndone, 0);
        check("rstmid.ready",   32'(ready), 1);

`ifdef ALU_SEQ_ABORT_EN
        // Abort in EXEC cycle 3 of a DIV
        ncomp = 0;
        issue(3'b011, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (compute) ncomp++;
        end
        check("abort.iter_at_abort", 32'(iter), 6);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort.compute", 32'(compute), 0);
        check("abort.done",    32'(done),    1);
        check("abort.error",   32'(error),   1);
        check("abort.iter",    32'(iter),    0);
        check("abort.computes", ncomp, 3);
        @(negedge clk);
        check("abort.ready", 32'(ready), 1);
        // Abort while idle has no effect
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort.idle_ignored", 32'(done), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Parametrised control sequencer for the iterative ALU: accepts an operation request and issues load/compute strobes to the datapath.
- Counts MUL/DIV iterations internally; no external zero_count.
- Returns a one-cycle done pulse with an error flag.
- Sits between the top-level command interface and the shift-add multiplier / non-restoring divider datapath. Generalised in operand width; adds illegal-opcode and divide-by-zero handling.

Parameters:
- DATA_W, 8, operand width; MUL and DIV each take exactly DATA_W compute cycles.
- CNT_W, $clog2(DATA_W+1), width of the iteration counter (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  operation request; accepted only when ready=1.
- opcode  in  3  000 ADD, 001 SUB, 010 MUL, 011 DIV, 1xx illegal.
- divisor_zero  in  1  datapath flag, valid in the LOAD cycle.
- ready  out  1  high in IDLE only.
- busy  out  1  high in LOAD, EXEC and DONE.
- load  out  1  datapath operand load strobe.
- compute  out  1  datapath iteration strobe.
- select_op  out  2  00 ADD, 01 SUB, 10 MUL, 11 DIV.
- iter  out  CNT_W  remaining iterations; DATA_W in the first EXEC cycle, 1 in the last.
- done  out  1  one-cycle completion pulse.
- error  out  1  valid with done: illegal opcode or division by zero.

Behaviour:
- Reset (asynchronous, active-high): state IDLE, op_q=0, counter=0.
  - ready=1; busy, load, compute, done, error = 0; select_op=00; iter=0.
  - Reset mid-operation abandons the operation; no done pulse is produced.
- States: IDLE, LOAD, EXEC, DONE (shared package encoding).
- IDLE:
  - start=1 latches opcode into op_q.
  - Legal opcode → LOAD. Illegal opcode → DONE with err_q=1.
  - start=0 → stay.
- LOAD: load=1, select_op=op_q[1:0].
  - ADD/SUB → DONE.
  - MUL → EXEC; counter=DATA_W.
  - DIV with divisor_zero=0 → EXEC; counter=DATA_W.
  - DIV with divisor_zero=1 → DONE, err_q=1; no compute cycles issued.
- EXEC: compute=1, select_op=op_q[1:0], iter=counter; counter decrements each cycle.
  - counter==1 → DONE, otherwise stay.
  - Exactly DATA_W compute cycles per operation.
- DONE: done=1, error=err_q, select_op=op_q[1:0]; → IDLE. err_q clears on the next accepted start.
- Latency, start accepted at edge k:
  - ADD/SUB: load in cycle k+1, done in cycle k+2.
  - MUL/DIV: done in cycle k+2+DATA_W.
  - Illegal opcode: done+error in cycle k+1.
- start while busy is ignored, with no queuing; this includes start during the DONE cycle.
  - Back-to-back throughput: a new start is accepted in the cycle after DONE.
- opcode is sampled only at acceptance; later opcode changes have no effect.
- All outputs are decoded from registered state and counter; no combinational path from any input to any output.

Optional Feature:
- Macro: ALU_SEQ_ABORT_EN.
- Defined: adds input port abort (1 bit).
  - abort=1 in LOAD or EXEC → DONE next cycle with error=1.
  - compute is deasserted from that edge; the counter is cleared.
  - abort in IDLE or DONE is ignored.
- Undefined: no abort port; behaviour exactly as above.

Decomposition:
- Package alu_pkg holds:
  - opcode constants (OP_ADD, OP_SUB, OP_MUL, OP_DIV);
  - select_op encodings;
  - state encoding localparams.
- One natural sub-module: iter_counter, a loadable down-counter of width CNT_W with load, dec and is_one outputs, instantiated once.

Test Plan (DATA_W=8):
- ADD: start with opcode=000 → load=1 exactly one cycle with select_op=00; done=1 two cycles after acceptance; error=0.
- MUL: opcode=010 → 8 consecutive compute cycles with iter counting 8..1; done at cycle k+10; error=0.
- DIV with divisor_zero=1 in the LOAD cycle → zero compute cycles; done=1 with error=1 at cycle k+2.
- Illegal opcode=101 → done=1, error=1 one cycle after acceptance; load never asserted.
- start pulsed during EXEC of MUL → ignored, single done. Then start in the cycle after done → accepted. rst asserted in EXEC cycle 4 → all outputs 0 immediately, ready=1, no done.
- With ALU_SEQ_ABORT_EN: abort in EXEC cycle 3 of DIV → compute drops next edge; done=1, error=1 one cycle later.
